peripheral_uart_fifo: RTL and testbench

- Parametrised, memory-mapped UART peripheral; next generation of the single-byte UART peripheral on the processor bus.
- Same bus handshake: cs/addr/rd/wr with 16-bit d_in/d_out.
- Adds internal TX/RX FIFOs, a run-time baud divisor, sticky error flags, a level register and an interrupt output.
- TX/RX serial engines live inside the block; no sub-UART instance.

---
 rtl/peripheral_uart_fifo_if.sv | 13 +
 rtl/peripheral_uart_fifo.sv | 276 +++++++++++++++++++++++++++
 tb/tb_peripheral_uart_fifo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/peripheral_uart_fifo_if.sv
// Processor bus bundle for the FIFO UART peripheral.
// The master drives the strobes; the slave returns registered read data.
interface peripheral_uart_fifo_if;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_in;
    logic [15:0] d_out;

    modport master (output cs, addr, rd, wr, d_in, input d_out);
    modport slave  (input cs, addr, rd, wr, d_in, output d_out);
endinterface

// File: rtl/peripheral_uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, run-time baud divisor, sticky errors, irq.
// Optional parity generation/checking is enabled by defining UART_PARITY_EN.
module peripheral_uart_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    peripheral_uart_fifo_if.slave bus,
    output logic                  tx,
    input  logic                  rx,
    output logic                  irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [3:0] LAST = 4'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_PARITY_EN
        , PAR
`endif
    } st_e;

    st_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [15:0] tx_tmr_q, tx_tmr_d, rx_tmr_q, rx_tmr_d;
    logic [15:0] tx_div_q, tx_div_d, rx_div_q, rx_div_d;
    logic [3:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic tx_q, tx_d, irq_q, irq_d;
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d, dout_q, dout_d;
    logic [2:0] ie_q, ie_d, rx_sync_q, rx_sync_d;
    logic [3:0] err_q, err_d;
`ifdef UART_PARITY_EN
    logic [1:0] par_q, par_d;
    logic tx_par_q, tx_par_d, rx_bad_q, rx_bad_d;
`endif

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];

    logic wr_en, rd_en, rx_line, rx_fall;
    logic tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush;
    logic [15:0] div_eff;
    logic [8:0] status;

    assign tx = tx_q;
    assign irq = irq_q;
    assign bus.d_out = dout_q;

    always_comb begin
        wr_en = bus.cs && bus.wr;
        rd_en = bus.cs && bus.rd;
        div_eff = (baud_q < 16'd4) ? 16'd4 : baud_q;
        rx_sync_d = {rx_sync_q[1:0], rx};
        rx_line = rx_sync_q[1];
        rx_fall = rx_sync_q[2] && !rx_sync_q[1];
        status = {err_q, tx_st_q != IDLE, rx_cnt_q == FULL,
                  rx_cnt_q != '0, tx_cnt_q == '0, tx_cnt_q == FULL};
        tx_st_d = tx_st_q; tx_tmr_d = tx_tmr_q; tx_div_d = tx_div_q;
        tx_bit_d = tx_bit_q; tx_sh_d = tx_sh_q; tx_d = tx_q;
        rx_st_d = rx_st_q; rx_tmr_d = rx_tmr_q; rx_div_d = rx_div_q;
        rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q;
        ctrl_d = ctrl_q; baud_d = baud_q; ie_d = ie_q; err_d = err_q;
        dout_d = dout_q;
`ifdef UART_PARITY_EN
        par_d = par_q; tx_par_d = tx_par_q; rx_bad_d = rx_bad_q;
`endif
        tx_push = 1'b0; tx_pop = 1'b0; rx_push = 1'b0; rx_pop = 1'b0;
        tx_flush = 1'b0; rx_flush = 1'b0;

        if (wr_en) begin
            case (bus.addr)
                4'h0: if (tx_cnt_q == FULL) err_d[0] = 1'b1;
                      else tx_push = 1'b1;
                4'h2: begin
                    ctrl_d = bus.d_in[1:0];
                    tx_flush = bus.d_in[2];
                    rx_flush = bus.d_in[3];
`ifdef UART_PARITY_EN
                    par_d = bus.d_in[5:4];
`endif
                end
                4'h4: err_d = err_q & ~bus.d_in[8:5];
                4'h8: baud_d = bus.d_in;
                4'hA: ie_d = bus.d_in[2:0];
                default: ;
            endcase
        end

        if (rd_en) begin
            dout_d = '0;
            case (bus.addr)
`ifdef UART_PARITY_EN
                4'h2: dout_d = {10'd0, par_q, 2'b00, ctrl_q};
`else
                4'h2: dout_d = {14'd0, ctrl_q};
`endif
                4'h4: dout_d = 16'(status);
                4'h6: if (rx_cnt_q != '0) begin
                    dout_d = 16'(rx_mem[rx_rp_q]);
                    rx_pop = 1'b1;
                end
                4'h8: dout_d = baud_q;
                4'hA: dout_d = 16'(ie_q);
                4'hC: dout_d = {8'(rx_cnt_q), 8'(tx_cnt_q)};
                default: ;
            endcase
        end

        unique case (tx_st_q)
            IDLE: if (ctrl_q[0] && tx_cnt_q != '0) begin
                tx_pop = 1'b1;
                tx_sh_d = tx_mem[tx_rp_q];
                tx_div_d = div_eff;
                tx_tmr_d = div_eff - 16'd1;
                tx_st_d = START;
                tx_d = 1'b0;
`ifdef UART_PARITY_EN
                tx_par_d = (^tx_mem[tx_rp_q]) ^ par_q[1];
`endif
            end
            START: if (tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - 16'd1;
            else begin
                tx_tmr_d = tx_div_q - 16'd1;
                tx_bit_d = '0;
                tx_st_d = DATA;
                tx_d = tx_sh_q[0];
            end
            DATA: if (tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - 16'd1;
            else begin
                tx_tmr_d = tx_div_q - 16'd1;
                if (tx_bit_q == LAST) begin
                    tx_st_d = STOP;
                    tx_d = 1'b1;
`ifdef UART_PARITY_EN
                    if (par_q[0]) begin
                        tx_st_d = PAR;
                        tx_d = tx_par_q;
                    end
`endif
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                    tx_sh_d = tx_sh_q >> 1;
                    tx_d = tx_sh_q[1];
                end
            end
`ifdef UART_PARITY_EN
            PAR: if (tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - 16'd1;
            else begin
                tx_tmr_d = tx_div_q - 16'd1;
                tx_st_d = STOP;
                tx_d = 1'b1;
            end
`endif
            STOP: if (tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - 16'd1;
                  else tx_st_d = IDLE;
            default: tx_st_d = IDLE;
        endcase

        // Start bit is re-checked half a bit period after the falling edge
        unique case (rx_st_q)
            IDLE: if (ctrl_q[1] && rx_fall) begin
                rx_st_d = START;
                rx_div_d = div_eff;
                rx_tmr_d = (div_eff >> 1) - 16'd1;
`ifdef UART_PARITY_EN
                rx_bad_d = 1'b0;
`endif
            end
            START: if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 16'd1;
            else if (rx_line) rx_st_d = IDLE;
            else begin
                rx_st_d = DATA;
                rx_tmr_d = rx_div_q - 16'd1;
                rx_bit_d = '0;
            end
            DATA: if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 16'd1;
            else begin
                rx_tmr_d = rx_div_q - 16'd1;
                rx_sh_d = {rx_line, rx_sh_q[DATA_W-1:1]};
                if (rx_bit_q == LAST) begin
                    rx_st_d = STOP;
`ifdef UART_PARITY_EN
                    if (par_q[0]) rx_st_d = PAR;
`endif
                end else rx_bit_d = rx_bit_q + 4'd1;
            end
`ifdef UART_PARITY_EN
            PAR: if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 16'd1;
            else begin
                rx_tmr_d = rx_div_q - 16'd1;
                rx_st_d = STOP;
                if (rx_line != ((^rx_sh_q) ^ par_q[1])) begin
                    err_d[3] = 1'b1;
                    rx_bad_d = 1'b1;
                end
            end
`endif
            STOP: if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 16'd1;
            else begin
                rx_st_d = IDLE;
                if (!rx_line) err_d[2] = 1'b1;
`ifdef UART_PARITY_EN
                else if (rx_bad_q) rx_push = 1'b0;
`endif
                else if (rx_cnt_q != FULL || rx_pop) rx_push = 1'b1;
                else err_d[1] = 1'b1;
            end
            default: rx_st_d = IDLE;
        endcase

        tx_wp_d = tx_wp_q + AW'(tx_push);
        tx_rp_d = tx_rp_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        if (tx_flush) begin
            tx_rp_d = tx_wp_q;
            tx_cnt_d = '0;
        end
        rx_wp_d = rx_wp_q + AW'(rx_push);
        rx_rp_d = rx_rp_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (rx_flush) begin
            rx_rp_d = rx_wp_d;
            rx_cnt_d = '0;
        end

        irq_d = (status[2] & ie_q[0]) | (status[1] & ie_q[1])
              | ((|err_q) & ie_q[2]);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= bus.d_in[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q <= IDLE; rx_st_q <= IDLE;
            tx_tmr_q <= '0; rx_tmr_q <= '0;
            tx_div_q <= 16'(DIV_RESET); rx_div_q <= 16'(DIV_RESET);
            tx_bit_q <= '0; rx_bit_q <= '0;
            tx_sh_q <= '0; rx_sh_q <= '0;
            tx_q <= 1'b1; irq_q <= 1'b0;
            tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
            rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
            ctrl_q <= '0; baud_q <= 16'(DIV_RESET);
            ie_q <= '0; err_q <= '0; dout_q <= '0;
            rx_sync_q <= '1;
`ifdef UART_PARITY_EN
            par_q <= '0; tx_par_q <= 1'b0; rx_bad_q <= 1'b0;
`endif
        end else begin
            tx_st_q <= tx_st_d; rx_st_q <= rx_st_d;
            tx_tmr_q <= tx_tmr_d; rx_tmr_q <= rx_tmr_d;
            tx_div_q <= tx_div_d; rx_div_q <= rx_div_d;
            tx_bit_q <= tx_bit_d; rx_bit_q <= rx_bit_d;
            tx_sh_q <= tx_sh_d; rx_sh_q <= rx_sh_d;
            tx_q <= tx_d; irq_q <= irq_d;
            tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; tx_cnt_q <= tx_cnt_d;
            rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d; rx_cnt_q <= rx_cnt_d;
            ctrl_q <= ctrl_d; baud_q <= baud_d;
            ie_q <= ie_d; err_q <= err_d; dout_q <= dout_d;
            rx_sync_q <= rx_sync_d;
`ifdef UART_PARITY_EN
            par_q <= par_d; tx_par_q <= tx_par_d; rx_bad_q <= rx_bad_d;
`endif
        end
    end
endmodule

// File: tb/tb_peripheral_uart_fifo.sv
// Scoreboard bench for peripheral_uart_fifo: reads queue expected data,
// a monitor compares d_out the cycle after each read strobe.
module tb_peripheral_uart_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;
    logic tx, rx, irq;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    string name_q[$];

    peripheral_uart_fifo_if bus();

    assign rx = loop ? tx : rx_drv;

    peripheral_uart_fifo #(
        .DATA_W(8), .FIFO_DEPTH(16), .DIV_RESET(434)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .tx(tx), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        if (bus.cs && bus.rd) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got 0x%04h with nothing expected", bus.d_out);
            end else begin
                chk(name_q.pop_front(), bus.d_out, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic rx_frame(input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            cyc(8);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        logic found, ok;
        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        bus.addr = '0; bus.d_in = '0;
        cyc(3);
        rst = 1'b0;

        // Reset values
        chk("tx_rst", 16'(tx), 16'h1);
        chk("irq_rst", 16'(irq), 16'h0);
        chk("dout_rst", bus.d_out, 16'h0);
        rd(4'h8, 16'd434, "baud_rst");
        rd(4'h2, 16'h0000, "ctrl_rst");
        rd(4'h4, 16'h0002, "status_rst");
        rd(4'h6, 16'h0000, "rxdata_empty");
        rd(4'hA, 16'h0000, "ie_rst");
        rd(4'hC, 16'h0000, "level_rst");
        wr(4'hE, 16'hFFFF);
        rd(4'hE, 16'h0000, "unmapped");

        // Single TX frame 0xA5 at 8 clocks per bit
        wr(4'h8, 16'd8);
        wr(4'h2, 16'h0001);
        wr(4'h0, 16'h00A5);
        frame = {1'b1, 8'hA5, 1'b0};
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            cyc(1);
            found = !tx;
        end
        chk("tx_start_seen", 16'(found), 16'h1);
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < 8; c++) begin
                if (b != 0 || c != 0) cyc(1);
                if (tx !== frame[b]) ok = 1'b0;
            end
            chk($sformatf("tx_bit%0d", b), 16'(ok), 16'h1);
        end
        cyc(2);
        rd(4'h4, 16'h0002, "status_tx_done");

        // Loopback two characters
        loop = 1'b1;
        wr(4'h2, 16'h0003);
        wr(4'h0, 16'h003C);
        wr(4'h0, 16'h00C3);
        cyc(250);
        rd(4'hC, 16'h0200, "level_rx2");
        rd(4'h6, 16'h003C, "rx_first");
        rd(4'h6, 16'h00C3, "rx_second");
        rd(4'h6, 16'h0000, "rx_empty_read");
        rd(4'hC, 16'h0000, "level_drained");

        // TX overflow with the engine disabled
        loop = 1'b0;
        wr(4'h2, 16'h0000);
        for (int i = 0; i < 17; i++) wr(4'h0, 16'(i));
        rd(4'hC, 16'h0010, "level_tx_full");
        rd(4'h4, 16'h0021, "status_tx_ovf");
        wr(4'h4, 16'h0020);
        rd(4'h4, 16'h0001, "status_ovf_clr");
        wr(4'h2, 16'h0004);
        rd(4'hC, 16'h0000, "level_flushed");
        rd(4'h2, 16'h0000, "ctrl_flush_clr");

        // Framing error and irq on sticky error
        wr(4'h2, 16'h0002);
        wr(4'hA, 16'h0004);
        cyc(2);
        chk("irq_quiet", 16'(irq), 16'h0);
        rx_frame({1'b0, 8'h55, 1'b0});
        rx_drv = 1'b1;
        cyc(2);
        chk("irq_frame_err", 16'(irq), 16'h1);
        rd(4'h4, 16'h0082, "status_frame_err");
        rd(4'hC, 16'h0000, "level_no_rx");
        wr(4'h4, 16'h0080);
        cyc(2);
        chk("irq_cleared", 16'(irq), 16'h0);

        // Short glitch must be rejected as a false start
        rx_drv = 1'b0;
        cyc(2);
        rx_drv = 1'b1;
        cyc(30);
        rd(4'hC, 16'h0000, "level_glitch");
        rd(4'h4, 16'h0002, "status_glitch");

        // Reset in the middle of a frame
        wr(4'h2, 16'h0001);
        wr(4'h0, 16'h0000);
        wr(4'h0, 16'h0000);
        cyc(20);
        chk("tx_low_midframe", 16'(tx), 16'h0);
        rd(4'hC, 16'h0001, "level_midframe");
        rst = 1'b1;
        cyc(1);
        chk("tx_after_rst", 16'(tx), 16'h1);
        chk("dout_after_rst", bus.d_out, 16'h0);
        rst = 1'b0;
        rd(4'hC, 16'h0000, "level_after_rst");
        rd(4'h8, 16'd434, "baud_after_rst");
        rd(4'h2, 16'h0000, "ctrl_after_rst");
        cyc(5);
        chk("tx_idle_after_rst", 16'(tx), 16'h1);

        chk("sb_drain", 16'(exp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
